// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock keypad datapath.
// Holds the FSM status encodings, the keypad digit width and the default
// code, plus the digit/code typedefs used across the lock blocks.
package lock_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DEF_DIGITS = 4;
    localparam logic [DEF_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234;

    typedef logic [DIGIT_W-1:0]            digit_t;
    typedef logic [DEF_DIGITS*DIGIT_W-1:0] code_t;

    // {fsm_bit1, fsm_bit2} as driven by the lock control FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPEN = 2'b01,
        ST_LOCK = 2'b10,
        ST_PROG = 2'b11
    } status_t;

endpackage

// File: rtl/lock_btn_edge.sv
// Rising-edge pulse generator for one debounced button.
// Ports:
//   clock, reset     - clock and asynchronous active-low reset
//   level            - synchronised, debounced button level
//   suppress         - blocks the pulse; the edge register still tracks level
//   edge_c           - combinational rising-edge detect (level & ~previous)
//   pulse            - registered one-cycle pulse, the cycle after the edge
module lock_btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    input  logic suppress,
    output logic edge_c,
    output logic pulse
);

    logic level_q;

    assign edge_c = level & ~level_q;

    // Previous level and the suppressible pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= edge_c & ~suppress;
        end
    end

endmodule

// File: rtl/lock_entry_datapath.sv
// Keypad-side datapath for the digital-lock control FSM.
// Collects keypad digits into a shift buffer (newest digit least significant),
// holds the secret code, and turns button edges into FSM pulses.
// Ports:
//   clock, reset            - clock and asynchronous active-low reset
//   key_valid/key_digit     - keypad digit strobe and value
//   key_clear               - discard the current entry
//   btn_enter/btn_change    - debounced button levels
//   fsm_load                - FSM load cycle: program code from last entry
//   fsm_bit1/fsm_bit2       - FSM status encoding
//   compare                 - buffer full and equal to code (combinational)
//   enter/change            - one-cycle pulses to the FSM
//   entry_count             - digits currently buffered
//   unlocked/lockout/prog_mode - status decode (combinational)
//   load_reject             - pulse: load attempted with an incomplete entry
module lock_entry_datapath
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS  = lock_pkg::DEF_DIGITS,
    parameter int unsigned DIGIT_W = lock_pkg::DIGIT_W,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [DIGIT_W-1:0]         key_digit,
    input  logic                       key_clear,
    input  logic                       btn_enter,
    input  logic                       btn_change,
    input  logic                       fsm_load,
    input  logic                       fsm_bit1,
    input  logic                       fsm_bit2,
    output logic                       compare,
    output logic                       enter,
    output logic                       change,
    output logic [$clog2(DIGITS+1)-1:0] entry_count,
    output logic                       unlocked,
    output logic                       lockout,
    output logic                       prog_mode,
    output logic                       load_reject
);

    localparam int unsigned CODE_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

    status_t            status_c;
    logic               full_c;
    logic               pulse_c;
    logic               enter_edge_c;
    logic               change_edge_c;
    logic [CODE_W-1:0]  buffer;
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  last_entry;
    logic               last_full;

    // Status decode straight from the FSM bits
    assign status_c  = status_t'({fsm_bit1, fsm_bit2});
    assign unlocked  = (status_c == ST_OPEN);
    assign lockout   = (status_c == ST_LOCK);
    assign prog_mode = (status_c == ST_PROG);

    assign full_c  = (entry_count == CNT_W'(DIGITS));
    assign compare = full_c && (buffer == code);
    assign pulse_c = enter | change;

    // Each button is suppressed by lockout and by the other button's edge,
    // so simultaneous edges yield no pulse at all.
    lock_btn_edge u_enter_edge (
        .clock    (clock),
        .reset    (reset),
        .level    (btn_enter),
        .suppress (lockout | change_edge_c),
        .edge_c   (enter_edge_c),
        .pulse    (enter)
    );

    lock_btn_edge u_change_edge (
        .clock    (clock),
        .reset    (reset),
        .level    (btn_change),
        .suppress (lockout | enter_edge_c),
        .edge_c   (change_edge_c),
        .pulse    (change)
    );

    // Entry buffer: a pulse cycle captures and clears, so the buffer never
    // moves while the FSM is sampling compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buffer      <= '0;
            entry_count <= '0;
        end else if (pulse_c || key_clear) begin
            buffer      <= '0;
            entry_count <= '0;
        end else if (key_valid && !lockout && !fsm_load && !full_c) begin
            buffer      <= (buffer << DIGIT_W) | CODE_W'(key_digit);
            entry_count <= entry_count + CNT_W'(1);
        end
    end

    // Last captured entry and its completeness; a load consumes it, and a
    // capture in the same cycle takes precedence for the next load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_entry <= '0;
            last_full  <= 1'b0;
        end else if (pulse_c) begin
            last_entry <= buffer;
            last_full  <= full_c;
        end else if (fsm_load) begin
            last_full  <= 1'b0;
        end
    end

    // Code register and the incomplete-load indication
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code        <= DEFAULT_CODE;
            load_reject <= 1'b0;
        end else begin
            load_reject <= fsm_load && !last_full;
            if (fsm_load && last_full) begin
                code <= last_entry;
            end
        end
    end

endmodule
